way_alloc_ctrl: RTL and testbench
=================================

WAY_ALLOC_CTRL -- requirements
Module: way_alloc_ctrl

Interface
REQ-001 SHALL provide parameter FILL_TIMEOUT, default 255, meaning max cycles in FILL_WAIT before abort (range 1..255, 8-bit counter).
REQ-002 SHALL use one clock and an asynchronous active-low reset: clk  input  1  clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 lk_valid  input  1  lookup result valid; lk_ready  output  1  controller accepts lookup.
REQ-005 lk_hit  input  1  lookup hit; lk_hit_way  input  2  hitting way; lk_way_valid  input  4  valid bits of addressed set.
REQ-006 lru_upd_valid  output  1  LRU access update strobe; lru_upd_way  output  2  accessed way.
REQ-007 lru_vic_req  output  1  victim request to 4-way tree PLRU; lru_vic_way  input  2  combinational victim returned same cycle.
REQ-008 fill_req  output  1  refill request; fill_way  output  2  way to refill; fill_ack  input  1  request accepted; fill_done  input  1  refill complete.
REQ-009 done_valid  output  1  completion pulse; done_way  output  2; done_hit  output  1; done_err  output  1; busy  output  1.

Function
REQ-010 FSM states SHALL be IDLE, HIT, SEL, FILL_REQ, FILL_WAIT, COMMIT; lk_ready=1 only in IDLE; busy=1 in any other state.
REQ-011 Lookup accepted when lk_valid&&lk_ready; lk_hit, lk_hit_way, lk_way_valid registered on acceptance.
REQ-012 Accepted hit -> HIT: one cycle lru_upd_valid=1, lru_upd_way=hit way, done_valid=1, done_hit=1, done_way=hit way; then IDLE (accept at N, pulses at N+1, lk_ready at N+2).
REQ-013 Accepted miss -> SEL (one cycle): if any registered valid bit is 0, select lowest-index invalid way, lru_vic_req stays 0; else lru_vic_req=1 for exactly that cycle and lru_vic_way captured as victim.
REQ-014 lru_vic_req and lru_upd_valid SHALL never be asserted in the same cycle (PLRU gives update priority).
REQ-015 FILL_REQ: fill_req=1, fill_way stable until fill_ack sampled 1; then FILL_WAIT.
REQ-016 fill_done in FILL_REQ without fill_ack SHALL be ignored; fill_ack and fill_done in the same cycle SHALL go directly to COMMIT.
REQ-017 FILL_WAIT: fill_req=0; fill_done=1 -> COMMIT.
REQ-018 COMMIT (one cycle): lru_upd_valid=1, lru_upd_way=fill way, done_valid=1, done_hit=0, done_way=fill way; then IDLE.
REQ-019 done_valid, lru_upd_valid, lru_vic_req SHALL be single-cycle pulses; lk_valid ignored while busy.

Reset
REQ-020 rst_n low SHALL immediately force IDLE and all outputs 0 except lk_ready=1; timeout counter and captured way cleared.
REQ-021 Reset mid-operation SHALL drop any pending fill request with no done_valid or LRU update generated.
REQ-022 First lookup SHALL be accepted on the first rising clk edge after rst_n deasserts.

Configuration
REQ-023 Macro WAY_ALLOC_TIMEOUT_EN defined: counter runs in FILL_WAIT from 0; reaching FILL_TIMEOUT with no fill_done -> IDLE, one cycle done_valid=1, done_err=1, done_way=fill way, no LRU update.
REQ-024 Macro undefined: no counter, FILL_WAIT waits indefinitely, done_err tied 0.

Verification
REQ-025 Hit: lk_valid=1, lk_hit=1, lk_hit_way=2 at cycle N -> N+1 lru_upd_valid=1/way=2, done_valid=1, done_hit=1; lk_ready=1 at N+2.
REQ-026 Miss, lk_way_valid=4'b1011 -> lru_vic_req never asserted, fill_way=2; after fill_ack then fill_done, COMMIT with lru_upd_way=2, done_hit=0.
REQ-027 Miss, lk_way_valid=4'b1111, lru_vic_way=3 -> lru_vic_req one cycle, fill_way=3, done_way=3.
REQ-028 Miss with fill_ack and fill_done same cycle -> COMMIT next cycle; fill_done before fill_ack -> ignored, fill_req held.
REQ-029 WAY_ALLOC_TIMEOUT_EN, FILL_TIMEOUT=4, no fill_done -> done_err=1 pulse 4 cycles into FILL_WAIT, no lru_upd_valid, back to IDLE.
REQ-030 rst_n low during FILL_WAIT -> fill_req=0, busy=0, lk_ready=1 immediately; no done_valid afterwards.

Source files
------------

// File: rtl/way_alloc_ctrl.sv
// Way allocation controller: acknowledges hits, picks a refill way on misses
// (first invalid way, else PLRU victim), runs the refill handshake and reports completion.
// Optional fill timeout abort is compiled in with `define WAY_ALLOC_TIMEOUT_EN.
module way_alloc_ctrl #(
  parameter int unsigned FILL_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lk_valid,
  output logic       lk_ready,
  input  logic       lk_hit,
  input  logic [1:0] lk_hit_way,
  input  logic [3:0] lk_way_valid,
  output logic       lru_upd_valid,
  output logic [1:0] lru_upd_way,
  output logic       lru_vic_req,
  input  logic [1:0] lru_vic_way,
  output logic       fill_req,
  output logic [1:0] fill_way,
  input  logic       fill_ack,
  input  logic       fill_done,
  output logic       done_valid,
  output logic [1:0] done_way,
  output logic       done_hit,
  output logic       done_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HIT       = 3'd1,
    SEL       = 3'd2,
    FILL_REQ  = 3'd3,
    FILL_WAIT = 3'd4,
    COMMIT    = 3'd5
  } state_t;

  state_t     state_q;
  logic [3:0] way_valid_q;
  logic [1:0] fill_way_q;
  logic [1:0] fill_way_d;
  logic       lk_ready_q;
  logic       busy_q;
  logic       upd_valid_q;
  logic [1:0] upd_way_q;
  logic       vic_req_q;
  logic       fill_req_q;
  logic       done_valid_q;
  logic [1:0] done_way_q;
  logic       done_hit_q;

`ifdef WAY_ALLOC_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(FILL_TIMEOUT - 1);
  logic       done_err_q;
  logic [7:0] tmo_cnt_q;
  assign done_err = done_err_q;
`else
  assign done_err = 1'b0;
`endif

  assign lk_ready      = lk_ready_q;
  assign busy          = busy_q;
  assign lru_upd_valid = upd_valid_q;
  assign lru_upd_way   = upd_way_q;
  assign lru_vic_req   = vic_req_q;
  assign fill_req      = fill_req_q;
  assign fill_way      = fill_way_q;
  assign done_valid    = done_valid_q;
  assign done_way      = done_way_q;
  assign done_hit      = done_hit_q;

  // Refill way: lowest-index invalid way, PLRU victim only when the set is full.
  always_comb begin
    logic [1:0] first_inv;
    first_inv = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!way_valid_q[i]) first_inv = 2'(i);
    end
    fill_way_d = (&way_valid_q) ? lru_vic_way : first_inv;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      way_valid_q  <= 4'd0;
      fill_way_q   <= 2'd0;
      lk_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      upd_valid_q  <= 1'b0;
      upd_way_q    <= 2'd0;
      vic_req_q    <= 1'b0;
      fill_req_q   <= 1'b0;
      done_valid_q <= 1'b0;
      done_way_q   <= 2'd0;
      done_hit_q   <= 1'b0;
`ifdef WAY_ALLOC_TIMEOUT_EN
      done_err_q   <= 1'b0;
      tmo_cnt_q    <= 8'd0;
`endif
    end else begin
      // Strobes default low so every pulse lasts exactly one cycle.
      upd_valid_q  <= 1'b0;
      upd_way_q    <= 2'd0;
      vic_req_q    <= 1'b0;
      done_valid_q <= 1'b0;
      done_way_q   <= 2'd0;
      done_hit_q   <= 1'b0;
`ifdef WAY_ALLOC_TIMEOUT_EN
      done_err_q   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (lk_valid && lk_ready_q) begin
            way_valid_q <= lk_way_valid;
            lk_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            if (lk_hit) begin
              state_q      <= HIT;
              upd_valid_q  <= 1'b1;
              upd_way_q    <= lk_hit_way;
              done_valid_q <= 1'b1;
              done_way_q   <= lk_hit_way;
              done_hit_q   <= 1'b1;
            end else begin
              state_q   <= SEL;
              vic_req_q <= &lk_way_valid;
            end
          end
        end
        HIT: begin
          state_q    <= IDLE;
          lk_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        SEL: begin
          state_q    <= FILL_REQ;
          fill_way_q <= fill_way_d;
          fill_req_q <= 1'b1;
        end
        FILL_REQ: begin
          // A fill_done without fill_ack is stale and deliberately dropped.
          if (fill_ack) begin
            fill_req_q <= 1'b0;
            if (fill_done) begin
              state_q      <= COMMIT;
              upd_valid_q  <= 1'b1;
              upd_way_q    <= fill_way_q;
              done_valid_q <= 1'b1;
              done_way_q   <= fill_way_q;
            end else begin
              state_q <= FILL_WAIT;
`ifdef WAY_ALLOC_TIMEOUT_EN
              tmo_cnt_q <= 8'd0;
`endif
            end
          end
        end
        FILL_WAIT: begin
          if (fill_done) begin
            state_q      <= COMMIT;
            upd_valid_q  <= 1'b1;
            upd_way_q    <= fill_way_q;
            done_valid_q <= 1'b1;
            done_way_q   <= fill_way_q;
`ifdef WAY_ALLOC_TIMEOUT_EN
          end else if (tmo_cnt_q == TMO_LAST) begin
            state_q      <= IDLE;
            lk_ready_q   <= 1'b1;
            busy_q       <= 1'b0;
            done_valid_q <= 1'b1;
            done_way_q   <= fill_way_q;
            done_err_q   <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + 8'd1;
`endif
          end
        end
        COMMIT: begin
          state_q    <= IDLE;
          lk_ready_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          lk_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          fill_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_way_alloc_ctrl.sv
// Scoreboard bench for way_alloc_ctrl: the driver pushes expected completions and
// LRU updates into queues, an independent monitor pops and compares them.
module tb_way_alloc_ctrl;

  localparam int TMO = 4;

  logic       clk;
  logic       rst_n;
  logic       lk_valid;
  logic       lk_ready;
  logic       lk_hit;
  logic [1:0] lk_hit_way;
  logic [3:0] lk_way_valid;
  logic       lru_upd_valid;
  logic [1:0] lru_upd_way;
  logic       lru_vic_req;
  logic [1:0] lru_vic_way;
  logic       fill_req;
  logic [1:0] fill_way;
  logic       fill_ack;
  logic       fill_done;
  logic       done_valid;
  logic [1:0] done_way;
  logic       done_hit;
  logic       done_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // Expected completion packed as {way[1:0], hit, err}.
  logic [3:0] exp_done[$];
  logic [1:0] exp_lru[$];

  way_alloc_ctrl #(.FILL_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .lk_valid(lk_valid), .lk_ready(lk_ready),
    .lk_hit(lk_hit), .lk_hit_way(lk_hit_way), .lk_way_valid(lk_way_valid),
    .lru_upd_valid(lru_upd_valid), .lru_upd_way(lru_upd_way),
    .lru_vic_req(lru_vic_req), .lru_vic_way(lru_vic_way),
    .fill_req(fill_req), .fill_way(fill_way), .fill_ack(fill_ack), .fill_done(fill_done),
    .done_valid(done_valid), .done_way(done_way), .done_hit(done_hit),
    .done_err(done_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: a full set evicts the PLRU victim, otherwise the lowest invalid way.
  function automatic logic [1:0] ref_way(input logic [3:0] m, input logic [1:0] v);
    if (m == 4'hF) return v;
    for (int i = 0; i < 4; i++) if (!m[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    lk_valid     = 1'($urandom);
    lk_hit       = 1'($urandom);
    lk_hit_way   = 2'($urandom);
    lk_way_valid = 4'($urandom);
  endtask

  task automatic do_hit(input logic [1:0] way);
    exp_done.push_back({way, 1'b1, 1'b0});
    exp_lru.push_back(way);
    cyc();
    lk_valid = 1'b1; lk_hit = 1'b1; lk_hit_way = way; lk_way_valid = 4'($urandom);
    @(negedge clk);
    chk("hit_accept_ready", 32'(lk_ready), 32'd1);
    cyc();
    junk();
    @(negedge clk);
    chk("hit_pulse", 32'({done_valid, done_hit, lru_upd_valid, busy, lru_vic_req}), 32'b11110);
    cyc();
    lk_valid = 1'b0;
    @(negedge clk);
    chk("hit_return", 32'({lk_ready, busy, done_valid, lru_upd_valid}), 32'b1000);
  endtask

  // mode 0: ack then done later, 1: ack+done same cycle, 2: early done before ack.
  task automatic do_miss(input logic [3:0] mask, input logic [1:0] vic, input int d_in,
                         input int mode, input int w);
    logic [1:0] ew;
    int d;
    d  = (mode == 2 && d_in == 0) ? 1 : d_in;
    ew = ref_way(mask, vic);
    exp_done.push_back({ew, 1'b0, 1'b0});
    exp_lru.push_back(ew);
    cyc();
    lk_valid = 1'b1; lk_hit = 1'b0; lk_hit_way = 2'($urandom); lk_way_valid = mask;
    lru_vic_way = vic; fill_ack = 1'b0; fill_done = 1'b0;
    @(negedge clk);
    chk("miss_accept_ready", 32'(lk_ready), 32'd1);
    cyc();
    junk();
    @(negedge clk);
    chk("sel_vic_req", 32'({lru_vic_req, busy, fill_req, lru_upd_valid}),
        32'({mask == 4'hF, 1'b1, 1'b0, 1'b0}));
    for (int c = 0; c <= d; c++) begin
      cyc();
      junk();
      lru_vic_way = 2'($urandom);
      fill_ack  = (c == d);
      fill_done = (c < d) ? ((mode == 2) ? 1'b1 : 1'($urandom)) : (mode == 1);
      @(negedge clk);
      chk("fill_req_hold", 32'({fill_req, fill_way, done_valid, busy}), 32'({1'b1, ew, 1'b0, 1'b1}));
    end
    if (mode != 1) begin
      for (int j = 0; j <= w; j++) begin
        cyc();
        junk();
        fill_ack = 1'b0; fill_done = (j == w);
        @(negedge clk);
        chk("fill_wait", 32'({fill_req, done_valid, busy}), 32'b001);
      end
    end
    cyc();
    junk();
    fill_ack = 1'b0; fill_done = 1'b0;
    @(negedge clk);
    chk("commit", 32'({done_valid, done_hit, lru_upd_valid, busy, fill_req}), 32'b10110);
    cyc();
    lk_valid = 1'b0;
    @(negedge clk);
    chk("commit_return", 32'({lk_ready, busy, done_valid}), 32'b100);
  endtask

`ifdef WAY_ALLOC_TIMEOUT_EN
  task automatic do_timeout(input logic [3:0] mask, input logic [1:0] vic);
    logic [1:0] ew;
    ew = ref_way(mask, vic);
    exp_done.push_back({ew, 1'b0, 1'b1});
    cyc();
    lk_valid = 1'b1; lk_hit = 1'b0; lk_way_valid = mask; lru_vic_way = vic;
    fill_ack = 1'b0; fill_done = 1'b0;
    cyc();
    junk();
    cyc();
    junk();
    fill_ack = 1'b1;
    for (int k = 0; k < TMO; k++) begin
      cyc();
      junk();
      fill_ack = 1'b0; fill_done = 1'b0;
      @(negedge clk);
      chk("tmo_wait", 32'({done_valid, fill_req, busy}), 32'b001);
    end
    cyc();
    lk_valid = 1'b0;
    @(negedge clk);
    chk("tmo_err", 32'({done_valid, done_err, lru_upd_valid, lk_ready, busy}), 32'b11010);
  endtask
`endif

  task automatic do_reset_mid_fill();
    cyc();
    lk_valid = 1'b1; lk_hit = 1'b0; lk_way_valid = 4'b0110; lru_vic_way = 2'd1;
    fill_ack = 1'b0; fill_done = 1'b0;
    cyc();
    lk_valid = 1'b0;
    cyc();
    fill_ack = 1'b1;
    cyc();
    fill_ack = 1'b0;
    @(negedge clk);
    chk("pre_reset_wait", 32'({fill_req, busy}), 32'b01);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    fill_done = 1'b1;
    #1;
    chk("reset_async", 32'({fill_req, busy, lk_ready, done_valid, lru_upd_valid, fill_way}),
        32'b0010000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      fill_done = (k == 0);
      @(negedge clk);
      chk("post_reset_quiet", 32'({done_valid, lru_upd_valid, lk_ready, busy}), 32'b0010);
    end
    fill_done = 1'b0;
  endtask

  // Monitor: every completion and LRU update must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done_valid === 1'b1) begin
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: actual way=%0d hit=%0d err=%0d required none",
                   done_way, done_hit, done_err);
        end else begin
          chk("done_fields", 32'({done_way, done_hit, done_err}), 32'(exp_done.pop_front()));
        end
      end
      if (lru_upd_valid === 1'b1) begin
        if (exp_lru.size() == 0) begin
          checks++; errors++;
          $display("FAIL lru_unexpected: actual way=%0d required none", lru_upd_way);
        end else begin
          chk("lru_upd_way", 32'(lru_upd_way), 32'(exp_lru.pop_front()));
        end
        chk("vic_upd_exclusive", 32'(lru_vic_req), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    lk_valid = 1'b0; lk_hit = 1'b0; lk_hit_way = 2'd0; lk_way_valid = 4'd0;
    lru_vic_way = 2'd0; fill_ack = 1'b0; fill_done = 1'b0;
    @(negedge clk);
    chk("reset_state",
        32'({lk_ready, busy, fill_req, fill_way, done_valid, done_way, done_hit, done_err,
             lru_upd_valid, lru_upd_way, lru_vic_req}),
        32'b1_0_0_00_0_00_0_0_0_00_0);
    @(negedge clk);
    // First lookup presented while leaving reset: accepted on the first rising edge.
    exp_done.push_back({2'd2, 1'b1, 1'b0});
    exp_lru.push_back(2'd2);
    lk_valid = 1'b1; lk_hit = 1'b1; lk_hit_way = 2'd2; lk_way_valid = 4'hF;
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_hit_pulse", 32'({done_valid, done_hit, lru_upd_valid, lru_upd_way, busy}), 32'b111101);
    cyc();
    lk_valid = 1'b0;
    @(negedge clk);
    chk("first_hit_ready", 32'({lk_ready, busy}), 32'b10);

    do_miss(4'b1011, 2'd0, 1, 0, 1);
    do_miss(4'b1111, 2'd3, 0, 0, 0);
    do_miss(4'b0000, 2'd3, 2, 1, 0);
    do_miss(4'b1111, 2'd1, 2, 2, 1);
    do_miss(4'b0111, 2'd0, 0, 1, 0);
    do_hit(2'd0);
    do_hit(2'd3);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_hit(2'($urandom));
      end else begin
        do_miss($urandom_range(0, 1) ? 4'hF : 4'($urandom), 2'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
      end
    end

`ifdef WAY_ALLOC_TIMEOUT_EN
    do_timeout(4'b1101, 2'd0);
    do_timeout(4'hF, 2'd3);
`endif

    do_reset_mid_fill();
    do_hit(2'd1);

    repeat (2) @(negedge clk);
    chk("sb_done_drained", 32'(exp_done.size()), 32'd0);
    chk("sb_lru_drained", 32'(exp_lru.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
